lcd_pattern_gen: RTL and testbench

- Test-pattern source sitting directly upstream of the LCD timing controller.
- Takes the controller's requested pixel coordinates and returns 24-bit RGB888 pixel data one cycle later.
- Sequences through five patterns, advancing on a key press or automatically every N frames.
- Pattern changes take effect only at frame boundaries, so no tearing occurs.

---
 rtl/lcd_pkg.sv | 49 ++++
 rtl/lcd_box_mover.sv | 67 ++++++
 rtl/lcd_pattern_gen.sv | 142 ++++++++++++++
 tb/tb_lcd_pattern_gen.sv | 302 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lcd_pkg.sv
// Shared types and constants for the LCD test-pattern generator.
package lcd_pkg;

  localparam int unsigned COORD_W      = 12;
  localparam int unsigned CH_W         = 8;
  localparam int unsigned PIX_W        = 3 * CH_W;
  localparam int unsigned PAT_W        = 3;
  localparam int unsigned DEF_H_ACTIVE = 800;
  localparam int unsigned DEF_V_ACTIVE = 480;

  // Pattern codes; 5..7 are never produced by the sequencer.
  typedef enum logic [PAT_W-1:0] {
    PAT_BARS  = 3'd0,
    PAT_GRID  = 3'd1,
    PAT_GRAD  = 3'd2,
    PAT_CHECK = 3'd3,
    PAT_BOX   = 3'd4
  } pattern_e;

  localparam pattern_e PAT_LAST = PAT_BOX;

  // One RGB888 pixel as presented on lcd_data.
  typedef struct packed {
    logic [CH_W-1:0] r;
    logic [CH_W-1:0] g;
    logic [CH_W-1:0] b;
  } rgb_t;

  localparam rgb_t WHITE   = 24'hFFFFFF;
  localparam rgb_t YELLOW  = 24'hFFFF00;
  localparam rgb_t CYAN    = 24'h00FFFF;
  localparam rgb_t GREEN   = 24'h00FF00;
  localparam rgb_t MAGENTA = 24'hFF00FF;
  localparam rgb_t RED     = 24'hFF0000;
  localparam rgb_t BLUE    = 24'h0000FF;
  localparam rgb_t BLACK   = 24'h000000;

  // Position and direction of one box axis.
  typedef struct packed {
    logic               dir_neg;
    logic [COORD_W-1:0] pos;
  } axis_t;

  // Successor in the pattern cycle, wrapping after the last pattern.
  function automatic pattern_e pattern_next(input pattern_e p);
    return (p == PAT_LAST) ? PAT_BARS : pattern_e'(p + 3'd1);
  endfunction

endpackage

// File: rtl/lcd_box_mover.sv
// Bouncing-box position: both axes step once per frame and reflect at the edges.
module lcd_box_mover
  import lcd_pkg::*;
#(
  parameter int unsigned H_ACTIVE = DEF_H_ACTIVE,
  parameter int unsigned V_ACTIVE = DEF_V_ACTIVE,
  parameter int unsigned BOX_SIZE = 64,
  parameter int unsigned BOX_STEP = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               frame_tick,
  output logic [COORD_W-1:0] box_x,
  output logic [COORD_W-1:0] box_y
);

  localparam int unsigned SUM_W = COORD_W + 1;

  axis_t x_q, x_d, y_q, y_d;

  // One bounce step on a single axis; sums are one bit wider so they never wrap.
  function automatic axis_t axis_step(input axis_t a, input logic [SUM_W-1:0] active);
    axis_t n;
    n = a;
    if (!a.dir_neg) begin
      if (SUM_W'(a.pos) + SUM_W'(BOX_SIZE) + SUM_W'(BOX_STEP) > active) begin
        n.dir_neg = 1'b1;
        n.pos     = a.pos - COORD_W'(BOX_STEP);
      end else begin
        n.pos     = a.pos + COORD_W'(BOX_STEP);
      end
    end else begin
      if (a.pos < COORD_W'(BOX_STEP)) begin
        n.dir_neg = 1'b0;
        n.pos     = a.pos + COORD_W'(BOX_STEP);
      end else begin
        n.pos     = a.pos - COORD_W'(BOX_STEP);
      end
    end
    return n;
  endfunction

  // Next position, advanced only on the frame boundary.
  always_comb begin
    x_d = x_q;
    y_d = y_q;
    if (frame_tick) begin
      x_d = axis_step(x_q, SUM_W'(H_ACTIVE));
      y_d = axis_step(y_q, SUM_W'(V_ACTIVE));
    end
  end

  // Position registers; reset parks the box at the origin heading +x/+y.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      x_q <= '0;
      y_q <= '0;
    end else begin
      x_q <= x_d;
      y_q <= y_d;
    end
  end

  assign box_x = x_q.pos;
  assign box_y = y_q.pos;

endmodule

// File: rtl/lcd_pattern_gen.sv
// Test-pattern source for the LCD timing controller: five patterns, switched only at frame end.
module lcd_pattern_gen
  import lcd_pkg::*;
#(
  parameter int unsigned H_ACTIVE           = DEF_H_ACTIVE,
  parameter int unsigned V_ACTIVE           = DEF_V_ACTIVE,
  parameter int unsigned FRAMES_PER_PATTERN = 120,
  parameter int unsigned BOX_SIZE           = 64,
  parameter int unsigned BOX_STEP           = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [COORD_W-1:0] lcd_xpos,
  input  logic [COORD_W-1:0] lcd_ypos,
  input  logic               key_next,
  input  logic               auto_en,
  output logic [PIX_W-1:0]   lcd_data,
  output logic [PAT_W-1:0]   pattern_id,
  output logic               frame_tick
);

  localparam int unsigned CNT_W = (FRAMES_PER_PATTERN > 1) ? $clog2(FRAMES_PER_PATTERN) : 1;
  localparam int unsigned BAR_W = H_ACTIVE / 8;
  localparam int unsigned SUM_W = COORD_W + 1;

  localparam logic [CNT_W-1:0]   CNT_LAST = CNT_W'(FRAMES_PER_PATTERN - 1);
  localparam logic [COORD_W-1:0] X_LAST   = COORD_W'(H_ACTIVE - 1);
  localparam logic [COORD_W-1:0] Y_LAST   = COORD_W'(V_ACTIVE - 1);

  pattern_e           pend_q, pend_d;
  pattern_e           pat_q, pat_d;
  logic [CNT_W-1:0]   frame_cnt_q, frame_cnt_d;
  logic               key_q;
  logic               last_px_q;
  logic               last_px_c;
  logic               key_rise_c;
  logic               auto_adv_c;
  logic               advance_c;
  logic               in_box_c;
  logic [COORD_W-1:0] box_x, box_y;
  rgb_t               pix_c;

  // Frame-end detection and advance sources.
  assign last_px_c  = (lcd_xpos == X_LAST) && (lcd_ypos == Y_LAST);
  assign key_rise_c = key_next & ~key_q;
  assign auto_adv_c = auto_en & frame_tick & (frame_cnt_q == CNT_LAST);
  assign advance_c  = key_rise_c | auto_adv_c;

  lcd_box_mover #(
    .H_ACTIVE (H_ACTIVE),
    .V_ACTIVE (V_ACTIVE),
    .BOX_SIZE (BOX_SIZE),
    .BOX_STEP (BOX_STEP)
  ) u_box (
    .clk        (clk),
    .rst_n      (rst_n),
    .frame_tick (frame_tick),
    .box_x      (box_x),
    .box_y      (box_y)
  );

  // Sequencer next state: pending pattern moves on any advance, live pattern follows at frame end.
  always_comb begin
    pend_d      = pend_q;
    pat_d       = pat_q;
    frame_cnt_d = frame_cnt_q;
    if (advance_c) begin
      pend_d      = pattern_next(pend_q);
      frame_cnt_d = '0;
    end else if (frame_tick) begin
      frame_cnt_d = (frame_cnt_q == CNT_LAST) ? '0 : frame_cnt_q + CNT_W'(1);
    end
    if (frame_tick) begin
      pat_d = pend_d;
    end
  end

  // Sequencer state registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pend_q      <= PAT_BARS;
      pat_q       <= PAT_BARS;
      frame_cnt_q <= '0;
    end else begin
      pend_q      <= pend_d;
      pat_q       <= pat_d;
      frame_cnt_q <= frame_cnt_d;
    end
  end

  assign in_box_c = (SUM_W'(lcd_xpos) >= SUM_W'(box_x)) &&
                    (SUM_W'(lcd_xpos) <  SUM_W'(box_x) + SUM_W'(BOX_SIZE)) &&
                    (SUM_W'(lcd_ypos) >= SUM_W'(box_y)) &&
                    (SUM_W'(lcd_ypos) <  SUM_W'(box_y) + SUM_W'(BOX_SIZE));

  // Pixel colour for the requested coordinate under the live pattern.
  always_comb begin
    pix_c = BLACK;
    if ((lcd_xpos < COORD_W'(H_ACTIVE)) && (lcd_ypos < COORD_W'(V_ACTIVE))) begin
      case (pat_q)
        PAT_BARS: begin
          if      (lcd_xpos < COORD_W'(BAR_W * 1)) pix_c = WHITE;
          else if (lcd_xpos < COORD_W'(BAR_W * 2)) pix_c = YELLOW;
          else if (lcd_xpos < COORD_W'(BAR_W * 3)) pix_c = CYAN;
          else if (lcd_xpos < COORD_W'(BAR_W * 4)) pix_c = GREEN;
          else if (lcd_xpos < COORD_W'(BAR_W * 5)) pix_c = MAGENTA;
          else if (lcd_xpos < COORD_W'(BAR_W * 6)) pix_c = RED;
          else if (lcd_xpos < COORD_W'(BAR_W * 7)) pix_c = BLUE;
          else                                     pix_c = BLACK;
        end
        PAT_GRID: begin
          if ((lcd_xpos[4:0] == 5'd0) || (lcd_ypos[4:0] == 5'd0) ||
              (lcd_xpos == X_LAST) || (lcd_ypos == Y_LAST)) begin
            pix_c = WHITE;
          end
        end
        PAT_GRAD:  pix_c = {lcd_xpos[9:2], lcd_xpos[9:2], lcd_xpos[9:2]};
        PAT_CHECK: pix_c = (lcd_xpos[5] ^ lcd_ypos[5]) ? WHITE : BLACK;
        PAT_BOX:   pix_c = in_box_c ? RED : BLACK;
        default:   pix_c = BLACK;
      endcase
    end
  end

  // Output and edge-detect registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      lcd_data   <= '0;
      frame_tick <= 1'b0;
      last_px_q  <= 1'b0;
      key_q      <= 1'b0;
    end else begin
      lcd_data   <= pix_c;
      frame_tick <= last_px_c & ~last_px_q;
      last_px_q  <= last_px_c;
      key_q      <= key_next;
    end
  end

  assign pattern_id = pat_q;

endmodule

// File: tb/tb_lcd_pattern_gen.sv
// Self-checking bench for lcd_pattern_gen: vector table, directed sequences and random traffic.
module tb_lcd_pattern_gen;

  localparam int H   = 800;
  localparam int V   = 480;
  localparam int FPP = 3;
  localparam int BS  = 64;
  localparam int BST = 2;

  logic        clk;
  logic        rst_n;
  logic [11:0] lcd_xpos;
  logic [11:0] lcd_ypos;
  logic        key_next;
  logic        auto_en;
  logic [23:0] lcd_data;
  logic [2:0]  pattern_id;
  logic        frame_tick;

  lcd_pattern_gen #(
    .H_ACTIVE           (H),
    .V_ACTIVE           (V),
    .FRAMES_PER_PATTERN (FPP),
    .BOX_SIZE           (BS),
    .BOX_STEP           (BST)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .lcd_xpos   (lcd_xpos),
    .lcd_ypos   (lcd_ypos),
    .key_next   (key_next),
    .auto_en    (auto_en),
    .lcd_data   (lcd_data),
    .pattern_id (pattern_id),
    .frame_tick (frame_tick)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_total = 0;
  int n_bad   = 0;

  // Reference state: pending/live pattern, frames since reset, per-pattern frame count.
  int m_pat, m_pend, m_cnt, m_frames;
  bit m_tick, m_last, m_key;

  typedef struct {
    int          pat;
    int          x;
    int          y;
    logic [23:0] exp;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  // Triangle-wave box position after n frames of bouncing over [0, span].
  function automatic int tri_pos(input int n, input int span, input int step);
    int half, m;
    half = span / step;
    m    = n % (2 * half);
    return (m <= half) ? m * step : (2 * half - m) * step;
  endfunction

  function automatic logic [23:0] pix_ref(input int pat, input int x, input int y,
                                          input int bx, input int by);
    logic [7:0] g;
    if (x >= H || y >= V) return 24'h0;
    case (pat)
      0: begin
        case (x / (H / 8))
          0: return 24'hFFFFFF;
          1: return 24'hFFFF00;
          2: return 24'h00FFFF;
          3: return 24'h00FF00;
          4: return 24'hFF00FF;
          5: return 24'hFF0000;
          6: return 24'h0000FF;
          default: return 24'h000000;
        endcase
      end
      1: return (x % 32 == 0 || y % 32 == 0 || x == H - 1 || y == V - 1) ? 24'hFFFFFF : 24'h0;
      2: begin
        g = 8'(x / 4);
        return {g, g, g};
      end
      3: return (((x / 32) % 2) != ((y / 32) % 2)) ? 24'hFFFFFF : 24'h0;
      4: return (x >= bx && x < bx + BS && y >= by && y < by + BS) ? 24'hFF0000 : 24'h0;
      default: return 24'h0;
    endcase
  endfunction

  // Present one coordinate for one clock, advance the reference, compare all outputs.
  task automatic cycle(input int x, input int y, input bit key, input bit aen);
    logic [23:0] e;
    bit          last;
    lcd_xpos = 12'(x);
    lcd_ypos = 12'(y);
    key_next = key;
    auto_en  = aen;
    last     = (x == H - 1) && (y == V - 1);
    if (!rst_n) begin
      e = 24'h0;
      m_pat = 0; m_pend = 0; m_cnt = 0; m_frames = 0;
      m_tick = 0; m_last = 0; m_key = 0;
    end else begin
      e = pix_ref(m_pat, x, y, tri_pos(m_frames, H - BS, BST), tri_pos(m_frames, V - BS, BST));
      if ((key && !m_key) || (aen && m_tick && m_cnt == FPP - 1)) begin
        m_pend = (m_pend + 1) % 5;
        m_cnt  = 0;
      end else if (m_tick) begin
        m_cnt = (m_cnt + 1) % FPP;
      end
      if (m_tick) begin
        m_pat = m_pend;
        m_frames++;
      end
      m_tick = last && !m_last;
      m_last = last;
      m_key  = key;
    end
    @(posedge clk);
    #1;
    chk($sformatf("data(%0d,%0d)", x, y), lcd_data, e);
    chk($sformatf("pattern_id(%0d,%0d)", x, y), 32'(pattern_id), m_pat);
    chk($sformatf("frame_tick(%0d,%0d)", x, y), 32'(frame_tick), 32'(m_tick));
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    cycle(0, 0, 0, 0);
    cycle(0, 0, 0, 0);
    rst_n = 1'b1;
  endtask

  // Request the last pixel, then let the tick land (optionally with a key edge on it).
  task automatic frame_end(input bit key_at_tick, input bit aen);
    cycle(H - 1, V - 1, 0, aen);
    cycle(0, 0, key_at_tick, aen);
    cycle(1, 0, 0, aen);
  endtask

  task automatic goto_pattern(input int p);
    int guard;
    guard = 0;
    while (m_pat != p && guard < 10) begin
      cycle(5, 5, 1, 0);
      cycle(6, 5, 0, 0);
      frame_end(0, 0);
      guard++;
    end
    chk("goto_pattern", 32'(pattern_id), p);
  endtask

  initial begin
    int   ticks, p0, bx, by, max_bx, max_by, r;
    bit   key, aen;

    lcd_xpos = '0; lcd_ypos = '0; key_next = 1'b0; auto_en = 1'b0; rst_n = 1'b0;

    // Reset state
    do_reset();
    chk("reset_data", 32'(lcd_data), 0);
    chk("reset_pattern", 32'(pattern_id), 0);
    chk("reset_tick", 32'(frame_tick), 0);

    // Top-line sweep through all bars
    for (int x = 0; x < H; x++) cycle(x, 0, 0, 0);

    // Held last pixel ticks once; mid-frame key takes effect only at that tick
    cycle(10, 10, 1, 0);
    cycle(11, 10, 0, 0);
    chk("pend_not_live", 32'(pattern_id), 0);
    ticks = 0;
    for (int k = 0; k < 5; k++) begin
      cycle(H - 1, V - 1, 0, 0);
      if (k == 0) chk("pre_tick_pattern", 32'(pattern_id), 0);
      ticks += int'(frame_tick);
    end
    cycle(0, 0, 0, 0);
    ticks += int'(frame_tick);
    chk("hold_ticks", ticks, 1);
    chk("post_tick_pattern", 32'(pattern_id), 1);

    // Fixed-point vector table
    vecs.push_back('{0,   0,   0, 24'hFFFFFF});
    vecs.push_back('{0,  99,   0, 24'hFFFFFF});
    vecs.push_back('{0, 100,   0, 24'hFFFF00});
    vecs.push_back('{0, 200,   9, 24'h00FFFF});
    vecs.push_back('{0, 300,   9, 24'h00FF00});
    vecs.push_back('{0, 400,   9, 24'hFF00FF});
    vecs.push_back('{0, 500,   9, 24'hFF0000});
    vecs.push_back('{0, 699,   9, 24'h0000FF});
    vecs.push_back('{0, 700,   0, 24'h000000});
    vecs.push_back('{0, 799,   0, 24'h000000});
    vecs.push_back('{0, 800,   0, 24'h000000});
    vecs.push_back('{0,  10, 480, 24'h000000});
    vecs.push_back('{1,  32,   7, 24'hFFFFFF});
    vecs.push_back('{1,  33,   7, 24'h000000});
    vecs.push_back('{1, 799,   5, 24'hFFFFFF});
    vecs.push_back('{1,   5, 479, 24'hFFFFFF});
    vecs.push_back('{2, 400,  17, 24'h646464});
    vecs.push_back('{2, 799,   0, 24'hC7C7C7});
    vecs.push_back('{2,   3,  10, 24'h000000});
    vecs.push_back('{3,  32,   0, 24'hFFFFFF});
    vecs.push_back('{3,  32,  32, 24'h000000});
    vecs.push_back('{3,   0,  32, 24'hFFFFFF});
    for (int i = 0; i < vecs.size(); i++) begin
      goto_pattern(vecs[i].pat);
      cycle(vecs[i].x, vecs[i].y, 0, 0);
      chk($sformatf("vec%0d", i), 32'(lcd_data), 32'(vecs[i].exp));
    end

    // Auto advance every FPP frames, then key coinciding with an auto advance
    do_reset();
    for (int f = 0; f < 16; f++) begin
      cycle(0, 0, 0, 1);
      chk($sformatf("auto_seq%0d", f), 32'(pattern_id), (f / 3) % 5);
      cycle(H - 1, V - 1, 0, 1);
      cycle(1, 0, 0, 1);
    end
    for (int g = 0; g < FPP && m_cnt != FPP - 1; g++) begin
      cycle(0, 0, 0, 1);
      cycle(H - 1, V - 1, 0, 1);
      cycle(1, 0, 0, 1);
    end
    p0 = m_pat;
    cycle(0, 0, 0, 1);
    frame_end(1, 1);
    chk("key_auto_once", 32'(pattern_id), (p0 + 1) % 5);

    // Two presses within one frame move two patterns
    p0 = m_pat;
    cycle(3, 3, 1, 0);
    cycle(3, 3, 0, 0);
    cycle(4, 3, 1, 0);
    cycle(4, 3, 0, 0);
    frame_end(0, 0);
    chk("double_key", 32'(pattern_id), (p0 + 2) % 5);

    // Bouncing box over 400 frames
    do_reset();
    goto_pattern(4);
    max_bx = 0;
    max_by = 0;
    for (int f = 0; f < 400; f++) begin
      bx = tri_pos(m_frames, H - BS, BST);
      by = tri_pos(m_frames, V - BS, BST);
      cycle(bx, by, 0, 0);
      chk("box_in", 32'(lcd_data), 32'hFF0000);
      cycle(bx + BS, by, 0, 0);
      chk("box_right", 32'(lcd_data), 0);
      chk("box_x", 32'(dut.box_x), bx);
      chk("box_y", 32'(dut.box_y), by);
      if (int'(dut.box_x) > max_bx) max_bx = int'(dut.box_x);
      if (int'(dut.box_y) > max_by) max_by = int'(dut.box_y);
      frame_end(0, 0);
    end
    chk("box_x_max", max_bx, H - BS);
    chk("box_y_max", max_by, V - BS);

    // Reset mid-frame in the checkerboard
    do_reset();
    goto_pattern(3);
    frame_end(0, 0);
    cycle(3, 3, 0, 0);
    rst_n = 1'b0;
    cycle(32, 0, 0, 0);
    chk("midrst_data", 32'(lcd_data), 0);
    chk("midrst_pattern", 32'(pattern_id), 0);
    chk("midrst_tick", 32'(frame_tick), 0);
    chk("midrst_frame_cnt", 32'(dut.frame_cnt_q), 0);
    chk("midrst_box_x", 32'(dut.box_x), 0);
    chk("midrst_box_y", 32'(dut.box_y), 0);
    rst_n = 1'b1;
    cycle(32, 0, 0, 0);
    chk("post_rst_bars", 32'(lcd_data), 32'hFFFFFF);

    // Random traffic against the reference
    aen = 1'b0;
    key = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      if (i % 300 == 0) aen = 1'($urandom_range(0, 1));
      r = int'($urandom_range(0, 7));
      if (r == 0) cycle(H - 1, V - 1, key, aen);
      else cycle(int'($urandom_range(0, 830)), int'($urandom_range(0, 500)), key, aen);
      key = ($urandom_range(0, 5) == 0);
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
